ram_fm_banked: RTL and testbench

Parametrised on-chip feature-map buffer and successor to the single-port pixel RAM. It has a wide word of N_LANE pixels, with:
- a write port with per-lane mask;
- an independent read port with configurable pipeline latency and a valid flag;
- a write-first collision bypass;
- a built-in clear sequencer.

It sits between the DMA (write side) and the PE array (read side).

---
 rtl/ram_fm_banked.sv | 198 +++++++++++++++++++
 tb/tb_ram_fm_banked.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fm_banked.sv
// Feature-map buffer: N_LANE-pixel words, masked write port, pipelined read port with
// write-first bypass, and a clear sequencer. Optional lane parity under RAM_FM_PARITY_EN.
module ram_fm_banked #(
   parameter int PX_W       = 8,
   parameter int N_LANE     = 4,
   parameter int DEPTH      = 1024,
   parameter int RD_LAT     = 1,
   parameter bit CLR_ON_RST = 1'b1,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef RAM_FM_PARITY_EN
   input  logic                     dbg_flip_par,
   output logic [N_LANE-1:0]        rd_perr,
`endif
   input  logic                     clr_start,
   output logic                     busy,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [N_LANE*PX_W-1:0]   wr_data,
   input  logic [N_LANE-1:0]        wr_mask,
   input  logic                     rd_en,
   input  logic [AW-1:0]            rd_addr,
   output logic                     rd_valid,
   output logic [N_LANE*PX_W-1:0]   rd_data
);

`ifdef RAM_FM_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int LW = PX_W + PB;
   localparam int WW = N_LANE * LW;
   localparam int DW = N_LANE * PX_W;
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] cnt, cnt_nx;
   logic [WW-1:0] mem [DEPTH];

   logic          wr_ok, rd_ok, rd_in_range, coll;
   logic [AW-1:0] rd_idx;
   logic [WW-1:0] old_word;
   logic [DW-1:0] rd_word;
   logic          vld_p0;
   logic [DW-1:0] data_p0;
`ifdef RAM_FM_PARITY_EN
   logic [N_LANE-1:0] perr_c, perr_p0;

   function automatic logic even_par(input logic [PX_W-1:0] d);
      return ^d;
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLR_ON_RST ? CLEAR : IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (clr_start) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         end
         CLEAR: begin
            if (cnt == LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy        = (state == CLEAR);
   assign wr_ok       = wr_en & ~busy & ({1'b0, wr_addr} < DEPTH_L);
   assign rd_ok       = rd_en & ~busy;
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
   assign rd_idx      = rd_in_range ? rd_addr : '0;
   assign coll        = wr_ok & rd_en & (rd_addr == wr_addr);

   // Storage has no reset; the clear sequencer owns the write port while busy.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < N_LANE; i++) begin
            if (wr_mask[i]) begin
               mem[wr_addr][i*LW +: PX_W] <= wr_data[i*PX_W +: PX_W];
`ifdef RAM_FM_PARITY_EN
               mem[wr_addr][i*LW + PX_W] <= even_par(wr_data[i*PX_W +: PX_W]) ^ dbg_flip_par;
`endif
            end
         end
      end
   end

   // Write-first merge: masked lanes of a same-address write win over stored data.
   always_comb begin
      old_word = mem[rd_idx];
      rd_word  = '0;
`ifdef RAM_FM_PARITY_EN
      perr_c   = '0;
`endif
      for (int i = 0; i < N_LANE; i++) begin
         if (coll && wr_mask[i]) begin
            rd_word[i*PX_W +: PX_W] = wr_data[i*PX_W +: PX_W];
         end else begin
            rd_word[i*PX_W +: PX_W] = old_word[i*LW +: PX_W];
`ifdef RAM_FM_PARITY_EN
            perr_c[i] = old_word[i*LW + PX_W] ^ even_par(old_word[i*LW +: PX_W]);
`endif
         end
      end
      if (!rd_in_range) begin
         rd_word = '0;
`ifdef RAM_FM_PARITY_EN
         perr_c  = '0;
`endif
      end
   end

   // Stage p0: first read register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
`ifdef RAM_FM_PARITY_EN
         perr_p0 <= '0;
`endif
      end else begin
         vld_p0 <= rd_ok;
         if (rd_ok) begin
            data_p0 <= rd_word;
`ifdef RAM_FM_PARITY_EN
            perr_p0 <= perr_c;
`endif
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic          vld_p1;
         logic [DW-1:0] data_p1;
`ifdef RAM_FM_PARITY_EN
         logic [N_LANE-1:0] perr_p1;
`endif
         // Stage p1: optional output register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_p1  <= 1'b0;
               data_p1 <= '0;
`ifdef RAM_FM_PARITY_EN
               perr_p1 <= '0;
`endif
            end else begin
               vld_p1 <= vld_p0;
               if (vld_p0) begin
                  data_p1 <= data_p0;
`ifdef RAM_FM_PARITY_EN
                  perr_p1 <= perr_p0;
`endif
               end
            end
         end
         assign rd_valid = vld_p1;
         assign rd_data  = data_p1;
`ifdef RAM_FM_PARITY_EN
         assign rd_perr  = perr_p1;
`endif
      end else begin : g_lat1
         assign rd_valid = vld_p0;
         assign rd_data  = data_p0;
`ifdef RAM_FM_PARITY_EN
         assign rd_perr  = perr_p0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_ram_fm_banked.sv
// Bench for ram_fm_banked: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// checked every cycle against a word-level reference memory.
module tb_ram_fm_banked;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int DW    = 32;

   logic          clk = 1'b0, rst = 1'b0, clr_start = 1'b0, dbg_flip_par = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [3:0]    wr_mask = '0;
   logic          busy1, busy2, rd_valid1, rd_valid2;
   logic [DW-1:0] rd_data1, rd_data2;
   logic [3:0]    rd_perr1, rd_perr2;

   always #5 clk = ~clk;

   ram_fm_banked #(.RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
`ifdef RAM_FM_PARITY_EN
      .dbg_flip_par(dbg_flip_par), .rd_perr(rd_perr1),
`endif
      .clr_start(clr_start), .busy(busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid1), .rd_data(rd_data1)
   );

   ram_fm_banked #(.RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst),
`ifdef RAM_FM_PARITY_EN
      .dbg_flip_par(dbg_flip_par), .rd_perr(rd_perr2),
`endif
      .clr_start(clr_start), .busy(busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid2), .rd_data(rd_data2)
   );

   // Reference model: word contents, per-lane injected parity faults, clear countdown
   logic [DW-1:0] mm [DEPTH];
   logic [3:0]    mf [DEPTH];
   int            busy_left;
   logic          pend_v;
   logic [DW-1:0] pend_d, last1, last2;
   logic [3:0]    pend_p, lp1, lp2;
   int            checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      for (int a = 0; a < DEPTH; a++) begin
         mm[a] = '0;
         mf[a] = '0;
      end
   endtask

   task automatic cycle(input logic ce, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [3:0] wm, input logic re,
                        input logic [AW-1:0] ra, input logic fl);
      logic          mbusy, ev, v2;
      logic [DW-1:0] ed, d2;
      logic [3:0]    ep, p2;
      clr_start = ce; wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
      rd_en = re; rd_addr = ra; dbg_flip_par = fl;
      mbusy = (busy_left > 0);
      ev = 1'b0; ed = '0; ep = '0;
      if (!mbusy && re) begin
         ev = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (we && wa == ra && wm[i]) begin
               ed[i*8 +: 8] = wd[i*8 +: 8];
               ep[i] = 1'b0;
            end else begin
               ed[i*8 +: 8] = mm[ra][i*8 +: 8];
               ep[i] = mf[ra][i];
            end
         end
      end
      if (!mbusy && we) begin
         for (int i = 0; i < 4; i++) begin
            if (wm[i]) begin
               mm[wa][i*8 +: 8] = wd[i*8 +: 8];
               mf[wa][i] = fl;
            end
         end
      end
      @(posedge clk); #1;
      if (mbusy) busy_left--;
      else if (ce) begin
         busy_left = DEPTH;
         model_zero();
      end
      v2 = pend_v; d2 = pend_d; p2 = pend_p;
      pend_v = ev; pend_d = ed; pend_p = ep;
      if (ev) begin last1 = ed; lp1 = ep; end
      if (v2) begin last2 = d2; lp2 = p2; end
      chk("busy1", 64'(busy1), 64'(busy_left > 0));
      chk("busy2", 64'(busy2), 64'(busy_left > 0));
      chk("rd_valid1", 64'(rd_valid1), 64'(ev));
      chk("rd_data1", 64'(rd_data1), 64'(last1));
      chk("rd_valid2", 64'(rd_valid2), 64'(v2));
      chk("rd_data2", 64'(rd_data2), 64'(last2));
`ifdef RAM_FM_PARITY_EN
      chk("rd_perr1", 64'(rd_perr1), 64'(lp1));
      chk("rd_perr2", 64'(rd_perr2), 64'(lp2));
`endif
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
      cycle(1'b0, 1'b1, a, d, m, 1'b0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, a, 1'b0);
   endtask

   task automatic do_reset();
      clr_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0; dbg_flip_par = 1'b0;
      rst = 1'b1;
      #2;
      chk("rst_valid1", 64'(rd_valid1), 64'd0);
      chk("rst_valid2", 64'(rd_valid2), 64'd0);
      chk("rst_data1", 64'(rd_data1), 64'd0);
      chk("rst_data2", 64'(rd_data2), 64'd0);
      chk("rst_busy", 64'(busy1), 64'd1);
`ifdef RAM_FM_PARITY_EN
      chk("rst_perr", 64'(rd_perr1), 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      busy_left = DEPTH;
      model_zero();
      pend_v = 1'b0; pend_d = '0; pend_p = '0;
      last1 = '0; last2 = '0; lp1 = '0; lp2 = '0;
   endtask

   initial begin
      int n;
      #1;
      do_reset();
      // Clear after reset: exactly DEPTH busy cycles
      n = 0;
      while (busy1 && n < 2000) begin
         idle(1);
         n++;
      end
      chk("clr_len", 64'(n), 64'(DEPTH));
      rd(10'd0);
      chk("clr_rd0", 64'(rd_data1), 64'd0);
      rd(10'd1023);
      chk("clr_rd1023", 64'(rd_valid1), 64'd1);

      // Masked write
      wr(10'd5, 32'h44332211, 4'b1111);
      wr(10'd5, 32'hAABBCCDD, 4'b0101);
      rd(10'd5);
      chk("masked_rd", 64'(rd_data1), 64'h44BB22DD);

      // Collision write-first
      wr(10'd7, 32'h01020304, 4'b1111);
      cycle(1'b0, 1'b1, 10'd7, 32'hF0F0F0F0, 4'b0011, 1'b1, 10'd7, 1'b0);
      chk("coll_rd", 64'(rd_data1), 64'h0102F0F0);
      rd(10'd7);
      chk("coll_after", 64'(rd_data1), 64'h0102F0F0);

      // Back-to-back streaming
      for (int a = 0; a < 8; a++) wr(AW'(a), 32'h11111111 * a, 4'b1111);
      for (int a = 0; a < 8; a++) rd(AW'(a));
      chk("stream_lat2_last", 64'(rd_valid2), 64'd1);
      idle(1);
      chk("stream_lat2_data7", 64'(rd_data2), 64'h77777777);
      idle(2);

      // Random traffic in a small window to provoke collisions
      for (int k = 0; k < 400; k++)
         cycle(1'b0, 1'($urandom), AW'($urandom_range(15)), $urandom, 4'($urandom),
               1'($urandom), AW'($urandom_range(15)), 1'b0);
      idle(2);

      // Clear mid-stream with gated write; in-flight read must still complete
      wr(10'd3, 32'h33333333, 4'b1111);
      rd(10'd2);
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, 10'd3, 1'b0);
      cycle(1'b0, 1'b1, 10'd3, 32'hDEADBEEF, 4'b1111, 1'b1, 10'd3, 1'b0);
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      idle(DEPTH - 2);
      chk("gate_done", 64'(busy1), 64'd0);
      rd(10'd3);
      chk("gate_rd3", 64'(rd_data1), 64'd0);

      // Reset at clear cycle 100 restarts the full clear
      wr(10'd4, 32'h12345678, 4'b1111);
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      idle(100);
      do_reset();
      n = 0;
      while (busy1 && n < 2000) begin
         idle(1);
         n++;
      end
      chk("rst_clr_len", 64'(n), 64'(DEPTH));
      rd(10'd4);
      chk("rst_clr_rd4", 64'(rd_data1), 64'd0);

`ifdef RAM_FM_PARITY_EN
      cycle(1'b0, 1'b1, 10'd9, 32'h5A5A5A5A, 4'b0010, 1'b0, '0, 1'b1);
      rd(10'd9);
      chk("par_flip", 64'(rd_perr1), 64'b0010);
      cycle(1'b0, 1'b1, 10'd9, 32'h5A5A5A5A, 4'b0010, 1'b0, '0, 1'b0);
      rd(10'd9);
      chk("par_clean", 64'(rd_perr1), 64'd0);
      idle(2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
